// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
//   Front-end for the active-low board push-buttons. Every key has its own
//   channel with a 2-FF synchroniser, a debouncer and a hold timer. Each
//   channel produces a debounced level and single-cycle registered events for
//   press, release, short press and long press. Downstream logic uses short
//   and long presses on KEY[0] to tell a mode reset from a general reset.
//
// Parameters
//   N_KEYS           number of independent key channels
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a level change
//   LONG_CYCLES      cycles from press acceptance to the long-press event
//                    (must be greater than DEBOUNCE_CYCLES)
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   key_n        raw button inputs, active-low, asynchronous, bouncing
//   key_level    debounced state, 1 = held
//   key_press    1-cycle pulse when a press is accepted
//   key_release  1-cycle pulse when a release is accepted
//   key_short    1-cycle pulse with key_release when no long press fired
//   key_long     1-cycle pulse when the hold reaches LONG_CYCLES, once per hold
// ---------------------------------------------------------------------------
module key_conditioner #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_short,
  output logic [N_KEYS-1:0] key_long
);

  localparam int unsigned CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG_HELD,
    REL_DB
  } state_t;

  // Two-stage synchroniser; resets to the released level.
  logic [N_KEYS-1:0] sync_q1;
  logic [N_KEYS-1:0] sync_q2;
  logic [N_KEYS-1:0] p;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign p = ~sync_q2;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    state_t        state_q, state_d;
    logic [CW-1:0] db_q, db_d;
    logic [CW-1:0] hold_q, hold_d;
    logic [CW-1:0] db_inc, hold_inc;
    logic          db_hit, long_hit;
    // Remembers which hold state REL_DB was entered from, so a single
    // REL_DB state can return to HELD or LONG_HELD and decide on key_short.
    logic          from_long_q, from_long_d;
    logic          press_d, release_d, short_d, long_d, level_d;
    logic          press_q, release_q, short_q, long_q, level_q;

    always_comb begin
      state_d     = state_q;
      db_d        = db_q;
      hold_d      = hold_q;
      from_long_d = from_long_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      short_d     = 1'b0;
      long_d      = 1'b0;

      // Saturating increments; "hit" means this increment reaches the limit.
      db_inc   = (db_q == DB_MAX) ? db_q : db_q + CW'(1);
      hold_inc = (hold_q == LONG_MAX) ? hold_q : hold_q + CW'(1);
      db_hit   = (db_inc == DB_MAX);
      long_hit = (hold_q != LONG_MAX) && (hold_inc == LONG_MAX);

      case (state_q)
        IDLE: begin
          db_d = '0;
          if (p[k]) begin
            state_d = PRESS_DB;
            db_d    = CW'(1);
          end
        end

        PRESS_DB: begin
          if (!p[k]) begin
            state_d = IDLE;
            db_d    = '0;
          end else begin
            db_d = db_inc;
            if (db_hit) begin
              state_d     = HELD;
              press_d     = 1'b1;
              hold_d      = '0;
              db_d        = '0;
              from_long_d = 1'b0;
            end
          end
        end

        HELD: begin
          hold_d = hold_inc;
          db_d   = '0;
          if (long_hit) begin
            long_d      = 1'b1;
            from_long_d = 1'b1;
            state_d     = LONG_HELD;
          end
          // A release starting in the long-press cycle still leaves via the
          // long path: from_long_d is already set above.
          if (!p[k]) begin
            state_d = REL_DB;
            db_d    = CW'(1);
          end
        end

        LONG_HELD: begin
          db_d = '0;
          if (!p[k]) begin
            state_d = REL_DB;
            db_d    = CW'(1);
          end
        end

        REL_DB: begin
          // The hold timer keeps running while a release is being debounced.
          if (!from_long_q) begin
            hold_d = hold_inc;
            if (long_hit) begin
              long_d      = 1'b1;
              from_long_d = 1'b1;
            end
          end
          if (p[k]) begin
            state_d = from_long_d ? LONG_HELD : HELD;
            db_d    = '0;
          end else begin
            db_d = db_inc;
            if (db_hit) begin
              state_d     = IDLE;
              release_d   = 1'b1;
              short_d     = ~from_long_d;
              db_d        = '0;
              hold_d      = '0;
              from_long_d = 1'b0;
            end
          end
        end

        default: begin
          state_d     = IDLE;
          db_d        = '0;
          hold_d      = '0;
          from_long_d = 1'b0;
        end
      endcase

      level_d = (state_d == HELD) || (state_d == LONG_HELD) || (state_d == REL_DB);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q     <= IDLE;
        db_q        <= '0;
        hold_q      <= '0;
        from_long_q <= 1'b0;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        short_q     <= 1'b0;
        long_q      <= 1'b0;
        level_q     <= 1'b0;
      end else begin
        state_q     <= state_d;
        db_q        <= db_d;
        hold_q      <= hold_d;
        from_long_q <= from_long_d;
        press_q     <= press_d;
        release_q   <= release_d;
        short_q     <= short_d;
        long_q      <= long_d;
        level_q     <= level_d;
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_short[k]   = short_q;
    assign key_long[k]    = long_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
module tb_key_conditioner;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_level, key_press, key_release, key_short, key_long;

  key_conditioner #(
    .N_KEYS         (N),
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_short  (key_short),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: debounced level changes once the synchronised input has
  // disagreed with it for D consecutive cycles; the hold time is counted from
  // press acceptance and the long event fires when it reaches L.
  logic [N-1:0] m_level = '0, m_press = '0, m_release = '0, m_short = '0, m_long = '0;
  bit   s1 [N];
  bit   s2 [N];
  int   run [N];
  int   hold [N];
  bit   fired [N];

  logic [5*N-1:0] dut_vec, m_vec;
  assign dut_vec = {key_level, key_press, key_release, key_short, key_long};
  assign m_vec   = {m_level, m_press, m_release, m_short, m_long};

  task automatic model_step(input logic [N-1:0] kn, input logic rst);
    for (int k = 0; k < N; k++) begin
      bit pr;
      m_press[k] = 1'b0; m_release[k] = 1'b0; m_short[k] = 1'b0; m_long[k] = 1'b0;
      if (rst) begin
        s1[k] = 1'b1; s2[k] = 1'b1;
        m_level[k] = 1'b0; run[k] = 0; hold[k] = 0; fired[k] = 1'b0;
      end else begin
        pr = !s2[k];
        if (!m_level[k]) begin
          if (pr) begin
            run[k]++;
            if (run[k] == D) begin
              m_level[k] = 1'b1; m_press[k] = 1'b1;
              run[k] = 0; hold[k] = 0; fired[k] = 1'b0;
            end
          end else run[k] = 0;
        end else begin
          if (!fired[k]) begin
            hold[k]++;
            if (hold[k] == L) begin
              fired[k] = 1'b1; m_long[k] = 1'b1;
            end
          end
          if (!pr) begin
            run[k]++;
            if (run[k] == D) begin
              m_level[k] = 1'b0; m_release[k] = 1'b1; m_short[k] = !fired[k];
              run[k] = 0;
            end
          end else run[k] = 0;
        end
        s2[k] = s1[k];
        s1[k] = kn[k];
      end
    end
  endtask

  // Drives one cycle of stimulus and advances the model; outputs are sampled
  // 1 time unit after the active edge.
  task automatic tick(input logic [N-1:0] kn, input logic rst);
    @(negedge clk);
    key_n = kn;
    reset = rst;
    @(posedge clk);
    model_step(kn, rst);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick('1, 1'b1);
      checks++;
      if (dut_vec !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got %h required 0", i, dut_vec);
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick('1, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got %h required %h", i, dut_vec, m_vec);
      end
    end
  endtask

  task automatic test_short_press();
    int press_c = -1, rel_c = -1, short_c = -1, longs = 0;
    for (int i = 0; i < 30; i++) begin
      tick(i < 10 ? 4'b1110 : 4'b1111, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL short_model cycle %0d: got %h required %h", i + 1, dut_vec, m_vec);
      end
      if (key_press[0])   press_c = i + 1;
      if (key_release[0]) rel_c = i + 1;
      if (key_short[0])   short_c = i + 1;
      if (key_long[0])    longs++;
    end
    checks++; if (press_c !== 6)  begin errors++; $display("FAIL short_press_cycle: got %0d required 6", press_c); end
    checks++; if (rel_c !== 16)   begin errors++; $display("FAIL short_release_cycle: got %0d required 16", rel_c); end
    checks++; if (short_c !== 16) begin errors++; $display("FAIL short_short_cycle: got %0d required 16", short_c); end
    checks++; if (longs !== 0)    begin errors++; $display("FAIL short_no_long: got %0d required 0", longs); end
  endtask

  task automatic test_long_press();
    int long_c = -1, longs = 0, rel_c = -1, shorts = 0;
    for (int i = 0; i < 52; i++) begin
      tick(i < 40 ? 4'b1110 : 4'b1111, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL long_model cycle %0d: got %h required %h", i + 1, dut_vec, m_vec);
      end
      if (key_long[0])    begin long_c = i + 1; longs++; end
      if (key_release[0]) rel_c = i + 1;
      if (key_short[0])   shorts++;
    end
    checks++; if (long_c !== 26) begin errors++; $display("FAIL long_cycle: got %0d required 26", long_c); end
    checks++; if (longs !== 1)   begin errors++; $display("FAIL long_once: got %0d required 1", longs); end
    checks++; if (rel_c !== 46)  begin errors++; $display("FAIL long_release_cycle: got %0d required 46", rel_c); end
    checks++; if (shorts !== 0)  begin errors++; $display("FAIL long_no_short: got %0d required 0", shorts); end
  endtask

  task automatic test_bounce();
    logic [N-1:0] seq [5] = '{4'b1110, 4'b1111, 4'b1110, 4'b1111, 4'b1110};
    int press_c = -1, early = 0;
    for (int i = 0; i < 26; i++) begin
      tick(i < 5 ? seq[i] : (i < 15 ? 4'b1110 : 4'b1111), 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL bounce_model cycle %0d: got %h required %h", i + 1, dut_vec, m_vec);
      end
      if (key_press[0] && press_c < 0) press_c = i + 1;
      if (i + 1 < 10 && (key_level[0] || key_press[0] || key_release[0])) early++;
    end
    checks++; if (press_c !== 10) begin errors++; $display("FAIL bounce_press_cycle: got %0d required 10", press_c); end
    checks++; if (early !== 0)    begin errors++; $display("FAIL bounce_no_early_event: got %0d required 0", early); end
  endtask

  task automatic test_held_glitch();
    int long_c = -1, rel_c = -1, level_drops = 0;
    for (int i = 0; i < 52; i++) begin
      tick((i < 40 && i != 10 && i != 11) ? 4'b1110 : 4'b1111, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL glitch_model cycle %0d: got %h required %h", i + 1, dut_vec, m_vec);
      end
      if (key_long[0])    long_c = i + 1;
      if (key_release[0] && rel_c < 0) rel_c = i + 1;
      if (i + 1 >= 6 && i + 1 < 46 && !key_level[0]) level_drops++;
    end
    checks++; if (long_c !== 26)     begin errors++; $display("FAIL glitch_long_cycle: got %0d required 26", long_c); end
    checks++; if (rel_c !== 46)      begin errors++; $display("FAIL glitch_first_release: got %0d required 46", rel_c); end
    checks++; if (level_drops !== 0) begin errors++; $display("FAIL glitch_level_steady: got %0d required 0", level_drops); end
  endtask

  task automatic test_reset_mid_hold();
    int press_a = -1, press_b = -1, rels = 0;
    for (int i = 0; i < 42; i++) begin
      tick(i < 30 ? 4'b1110 : 4'b1111, i == 15);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL rst_hold_model cycle %0d: got %h required %h", i + 1, dut_vec, m_vec);
      end
      if (i == 15) begin
        checks++;
        if (dut_vec !== '0) begin
          errors++;
          $display("FAIL rst_hold_outputs: got %h required 0", dut_vec);
        end
      end
      if (key_press[0]) begin
        if (press_a < 0) press_a = i + 1; else if (press_b < 0) press_b = i + 1;
      end
      if (i < 30 && (key_release[0] || key_short[0])) rels++;
    end
    checks++; if (press_a !== 6)  begin errors++; $display("FAIL rst_hold_first_press: got %0d required 6", press_a); end
    checks++; if (press_b !== 22) begin errors++; $display("FAIL rst_hold_new_press: got %0d required 22", press_b); end
    checks++; if (rels !== 0)     begin errors++; $display("FAIL rst_hold_no_release: got %0d required 0", rels); end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] first_press = '0;
    int press_cycles = 0, press_c = -1;
    for (int i = 0; i < 22; i++) begin
      tick(i < 10 ? 4'b0110 : 4'b1111, 1'b0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL simul_model cycle %0d: got %h required %h", i + 1, dut_vec, m_vec);
      end
      if (key_press !== '0) begin
        press_cycles++;
        if (press_c < 0) begin press_c = i + 1; first_press = key_press; end
      end
    end
    checks++; if (first_press !== 4'b1001) begin errors++; $display("FAIL simul_press_vec: got %b required 1001", first_press); end
    checks++; if (press_c !== 6)           begin errors++; $display("FAIL simul_press_cycle: got %0d required 6", press_c); end
    checks++; if (press_cycles !== 1)      begin errors++; $display("FAIL simul_single_cycle: got %0d required 1", press_cycles); end
  endtask

  task automatic test_random();
    logic [N-1:0] kn = '1;
    int rem [N];
    for (int k = 0; k < N; k++) rem[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (rem[k] == 0) begin
          kn[k] = 1'($urandom_range(0, 1));
          rem[k] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(4, 40));
        end
        rem[k]--;
      end
      tick(kn, $urandom_range(0, 399) == 0);
      checks++;
      if (dut_vec !== m_vec) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %h required %h", i + 1, dut_vec, m_vec);
      end
    end
    for (int i = 0; i < 10; i++) tick('1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_bounce();
    test_held_glitch();
    test_reset_mid_hold();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
